// File: rtl/wep_pkg.sv
// Shared definitions for the WEP pre-processing and encrypt stages.
package wep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_BYTE = 3'd3,
    ST_ICV1 = 3'd4,
    ST_ICV2 = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam int          ICV_BYTES  = 4;

  // First ICV write word: the frame's trailing partial bytes stay in the
  // low lanes, the ICV starts right after them.
  function automatic logic [31:0] icv_first_word(input logic [31:0] icv_w,
                                                 input logic [23:0] last,
                                                 input logic [1:0]  tail);
    logic [31:0] w;
    case (tail)
      2'd0:    w = icv_w;
      2'd1:    w = {icv_w[23:0], last[7:0]};
      2'd2:    w = {icv_w[15:0], last[15:0]};
      default: w = {icv_w[7:0],  last[23:0]};
    endcase
    return w;
  endfunction

  // Second ICV write word: the ICV bytes that spilled past the first word,
  // zero-filled above.
  function automatic logic [31:0] icv_second_word(input logic [31:0] icv_w,
                                                  input logic [1:0]  tail);
    logic [31:0] w;
    case (tail)
      2'd1:    w = {24'd0, icv_w[31:24]};
      2'd2:    w = {16'd0, icv_w[31:16]};
      2'd3:    w = {8'd0,  icv_w[31:8]};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// Reflected CRC-32 advanced by one byte, LSB first.
module crc32_byte_update
  import wep_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_next
);

  // Eight unrolled shift/XOR steps.
  always_comb begin
    logic [31:0] c;
    c = crc ^ {24'd0, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/wep_icv_append.sv
// Reads a frame from SRAM port A, computes the WEP ICV (CRC-32) and writes
// it right after the frame so the encrypt stage can run in place.
//
// state | meaning
// IDLE  | waiting for start_icv
// RD    | issue next word read, or move on to the ICV writes
// WAIT  | SRAM read latency
// BYTE  | fold one byte of the read word into the CRC per cycle
// ICV1  | first ICV write (merged with the frame's partial tail word)
// ICV2  | second ICV write when the frame length is not word aligned
// DONE  | one-cycle completion pulse, results loaded
module wep_icv_append
  import wep_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_icv,
  input  logic [31:0] plain_addr,
  input  logic [31:0] frame_size,
  input  logic [31:0] port_A_data_out,
  output logic [31:0] port_A_data_in,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic        port_A_clk,
  output logic        busy,
  output logic        done,
  output logic [31:0] icv_frame_size,
  output logic [31:0] icv
);

  state_t      state, state_n;
  logic [15:0] base, base_n;
  logic [31:0] size, size_n;
  logic [31:0] count, count_n;
  logic [1:0]  bi, bi_n;
  logic [31:0] crc, crc_n, crc_upd;
  logic [23:0] last_word, last_word_n;
  logic [15:0] addr_n;
  logic        we_n;
  logic [31:0] data_n;
  logic        busy_n, done_n;
  logic [31:0] icv_frame_size_n, icv_n;

  logic [7:0]  cur_byte;
  logic [31:0] icv_word;
  logic [1:0]  tail;
  logic [15:0] wr_base;
  logic        unused_bits;

  // SRAM addresses are 16 bits, so the upper address bits never matter.
  assign unused_bits = ^plain_addr[31:16];

  assign port_A_clk = clk;
  assign tail       = size[1:0];
  assign icv_word   = ~crc;
  assign wr_base    = base + {size[15:2], 2'b00};

  // Select the byte lane addressed by bi from the stable read word.
  always_comb begin
    case (bi)
      2'd0:    cur_byte = port_A_data_out[7:0];
      2'd1:    cur_byte = port_A_data_out[15:8];
      2'd2:    cur_byte = port_A_data_out[23:16];
      default: cur_byte = port_A_data_out[31:24];
    endcase
  end

  crc32_byte_update u_crc (
    .crc       (crc),
    .data_byte (cur_byte),
    .crc_next  (crc_upd)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      base           <= '0;
      size           <= '0;
      count          <= '0;
      bi             <= '0;
      crc            <= '0;
      last_word      <= '0;
      port_A_addr    <= '0;
      port_A_we      <= 1'b0;
      port_A_data_in <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      icv_frame_size <= '0;
      icv            <= '0;
    end else begin
      state          <= state_n;
      base           <= base_n;
      size           <= size_n;
      count          <= count_n;
      bi             <= bi_n;
      crc            <= crc_n;
      last_word      <= last_word_n;
      port_A_addr    <= addr_n;
      port_A_we      <= we_n;
      port_A_data_in <= data_n;
      busy           <= busy_n;
      done           <= done_n;
      icv_frame_size <= icv_frame_size_n;
      icv            <= icv_n;
    end
  end

  // Next-state and next-register logic; SRAM outputs are registered so they
  // take the values of the state being entered.
  always_comb begin
    state_n          = state;
    base_n           = base;
    size_n           = size;
    count_n          = count;
    bi_n             = bi;
    crc_n            = crc;
    last_word_n      = last_word;
    addr_n           = port_A_addr;
    we_n             = 1'b0;
    data_n           = port_A_data_in;
    busy_n           = busy;
    done_n           = 1'b0;
    icv_frame_size_n = icv_frame_size;
    icv_n            = icv;

    case (state)
      ST_IDLE: begin
        if (start_icv) begin
          base_n  = plain_addr[15:0];
          size_n  = frame_size;
          crc_n   = CRC32_INIT;
          count_n = '0;
          busy_n  = 1'b1;
          state_n = ST_RD;
        end
      end

      ST_RD: begin
        if (count >= size) begin
          we_n    = 1'b1;
          addr_n  = wr_base;
          data_n  = icv_first_word(icv_word, last_word, tail);
          state_n = ST_ICV1;
        end else begin
          addr_n  = base + count[15:0];
          state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        bi_n    = '0;
        state_n = ST_BYTE;
      end

      ST_BYTE: begin
        if (bi == 2'd0) begin
          last_word_n = port_A_data_out[23:0];
        end
        crc_n = crc_upd;
        bi_n  = bi + 2'd1;
        if (bi == 2'd3 || (count + 32'(bi) + 32'd1) == size) begin
          count_n = count + 32'(ICV_BYTES);
          state_n = ST_RD;
        end
      end

      ST_ICV1: begin
        if (tail != 2'd0) begin
          we_n    = 1'b1;
          addr_n  = port_A_addr + 16'(ICV_BYTES);
          data_n  = icv_second_word(icv_word, tail);
          state_n = ST_ICV2;
        end else begin
          done_n           = 1'b1;
          icv_frame_size_n = size + 32'(ICV_BYTES);
          icv_n            = icv_word;
          state_n          = ST_DONE;
        end
      end

      ST_ICV2: begin
        done_n           = 1'b1;
        icv_frame_size_n = size + 32'(ICV_BYTES);
        icv_n            = icv_word;
        state_n          = ST_DONE;
      end

      ST_DONE: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wep_icv_append.sv
// Directed bench for wep_icv_append with a one-cycle-latency SRAM model.
module tb_wep_icv_append;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_icv;
  logic [31:0] plain_addr;
  logic [31:0] frame_size;
  logic [31:0] port_A_data_out;
  logic [31:0] port_A_data_in;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic        port_A_clk;
  logic        busy;
  logic        done;
  logic [31:0] icv_frame_size;
  logic [31:0] icv;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wep_icv_append dut (
    .clk             (clk),
    .reset           (reset),
    .start_icv       (start_icv),
    .plain_addr      (plain_addr),
    .frame_size      (frame_size),
    .port_A_data_out (port_A_data_out),
    .port_A_data_in  (port_A_data_in),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_clk      (port_A_clk),
    .busy            (busy),
    .done            (done),
    .icv_frame_size  (icv_frame_size),
    .icv             (icv)
  );

  // SRAM model: registered read, write on we; bench preloads via ld_*.
  logic [31:0] mem [0:16383];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  int          wr_count = 0;
  logic [15:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr[15:2]] <= ld_data;
    end else if (port_A_we) begin
      mem[port_A_addr[15:2]] <= port_A_data_in;
      if (wr_count < 32) begin
        wr_addr[wr_count] <= port_A_addr;
        wr_data[wr_count] <= port_A_data_in;
      end
      wr_count <= wr_count + 1;
    end
    port_A_data_out <= mem[port_A_addr[15:2]];
  end

  logic [7:0] ref_bytes [0:15];

  // Bitwise reference CRC-32 over ref_bytes[0..n-1], returns the ICV.
  function automatic logic [31:0] icv_ref(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {24'd0, ref_bytes[k]};
      for (int j = 0; j < 8; j++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic load_word(input logic [15:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Launch one run and count edges until done rises (bounded).
  task automatic do_run(input logic [31:0] a, input logic [31:0] n, output int edges);
    plain_addr = a; frame_size = n; start_icv = 1'b1;
    @(posedge clk); #1;
    start_icv = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (port_A_we !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %h want 0", port_A_we); end
    compared++; if (port_A_addr !== 16'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", port_A_addr); end
    compared++; if (port_A_data_in !== 32'h0) begin mismatched++; $display("FAIL reset_data_in: got %h want 0", port_A_data_in); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %h want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %h want 0", done); end
    compared++; if (icv_frame_size !== 32'h0) begin mismatched++; $display("FAIL reset_ifs: got %h want 0", icv_frame_size); end
    compared++; if (icv !== 32'h0) begin mismatched++; $display("FAIL reset_icv: got %h want 0", icv); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_crc_check;
    int e, wb;
    load_word(16'h0100, 32'h34333231);
    load_word(16'h0104, 32'h38373635);
    load_word(16'h0108, 32'h00000039);
    wb = wr_count;
    do_run(32'h100, 32'd9, e);
    compared++; if (e != 18) begin mismatched++; $display("FAIL crc_done_edges: got %0d want 18", e); end
    compared++; if (icv !== 32'hCBF43926) begin mismatched++; $display("FAIL crc_icv: got %h want cbf43926", icv); end
    compared++; if (icv_frame_size !== 32'd13) begin mismatched++; $display("FAIL crc_ifs: got %0d want 13", icv_frame_size); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL crc_busy_in_done: got %h want 1", busy); end
    compared++; if (wr_count - wb != 2) begin mismatched++; $display("FAIL crc_write_count: got %0d want 2", wr_count - wb); end
    compared++; if (wr_addr[wb] !== 16'h0108 || wr_data[wb] !== 32'hF4392639) begin mismatched++; $display("FAIL crc_write1: got %h@%h want f4392639@0108", wr_data[wb], wr_addr[wb]); end
    compared++; if (wr_addr[wb+1] !== 16'h010C || wr_data[wb+1] !== 32'h000000CB) begin mismatched++; $display("FAIL crc_write2: got %h@%h want 000000cb@010c", wr_data[wb+1], wr_addr[wb+1]); end
    @(posedge clk); #1;
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL crc_done_pulse: got %h want 0", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL crc_busy_after: got %h want 0", busy); end
    compared++; if (icv !== 32'hCBF43926) begin mismatched++; $display("FAIL crc_icv_held: got %h want cbf43926", icv); end
  endtask

  task automatic test_zero_word;
    int e, wb;
    load_word(16'h0000, 32'h00000000);
    wb = wr_count;
    do_run(32'h0, 32'd4, e);
    compared++; if (e != 8) begin mismatched++; $display("FAIL zero_done_edges: got %0d want 8", e); end
    compared++; if (icv !== 32'h2144DF1C) begin mismatched++; $display("FAIL zero_icv: got %h want 2144df1c", icv); end
    compared++; if (icv_frame_size !== 32'd8) begin mismatched++; $display("FAIL zero_ifs: got %0d want 8", icv_frame_size); end
    compared++; if (wr_count - wb != 1) begin mismatched++; $display("FAIL zero_write_count: got %0d want 1", wr_count - wb); end
    compared++; if (wr_addr[wb] !== 16'h0004 || wr_data[wb] !== 32'h2144DF1C) begin mismatched++; $display("FAIL zero_write: got %h@%h want 2144df1c@0004", wr_data[wb], wr_addr[wb]); end
    @(posedge clk); #1;
  endtask

  task automatic test_empty_frame;
    int e, wb;
    load_word(16'h0040, 32'hA5A5A5A5);
    wb = wr_count;
    do_run(32'h40, 32'd0, e);
    compared++; if (e != 2) begin mismatched++; $display("FAIL empty_done_edges: got %0d want 2", e); end
    compared++; if (icv !== 32'h0) begin mismatched++; $display("FAIL empty_icv: got %h want 0", icv); end
    compared++; if (icv_frame_size !== 32'd4) begin mismatched++; $display("FAIL empty_ifs: got %0d want 4", icv_frame_size); end
    compared++; if (wr_count - wb != 1) begin mismatched++; $display("FAIL empty_write_count: got %0d want 1", wr_count - wb); end
    compared++; if (mem[16'h0040 >> 2] !== 32'h0) begin mismatched++; $display("FAIL empty_mem: got %h want 0", mem[16'h0040 >> 2]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int wb, dn;
    load_word(16'h0200, 32'h34333231);
    load_word(16'h0204, 32'h38373635);
    load_word(16'h0208, 32'h00000039);
    load_word(16'h020C, 32'h5A5A5A5A);
    wb = wr_count;
    plain_addr = 32'h200; frame_size = 32'd9; start_icv = 1'b1;
    @(posedge clk); #1;
    start_icv = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    compared++; if (port_A_we !== 1'b0) begin mismatched++; $display("FAIL abort_we: got %h want 0", port_A_we); end
    compared++; if (port_A_addr !== 16'h0) begin mismatched++; $display("FAIL abort_addr: got %h want 0", port_A_addr); end
    compared++; if (port_A_data_in !== 32'h0) begin mismatched++; $display("FAIL abort_data_in: got %h want 0", port_A_data_in); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %h want 0", busy); end
    compared++; if (icv_frame_size !== 32'h0) begin mismatched++; $display("FAIL abort_ifs: got %h want 0", icv_frame_size); end
    compared++; if (icv !== 32'h0) begin mismatched++; $display("FAIL abort_icv: got %h want 0", icv); end
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    compared++; if (dn != 0) begin mismatched++; $display("FAIL abort_done_seen: got %0d want 0", dn); end
    compared++; if (wr_count != wb) begin mismatched++; $display("FAIL abort_writes: got %0d want 0", wr_count - wb); end
    compared++; if (mem[16'h020C >> 2] !== 32'h5A5A5A5A) begin mismatched++; $display("FAIL abort_mem: got %h want 5a5a5a5a", mem[16'h020C >> 2]); end
  endtask

  task automatic test_wrap;
    int e, wb;
    logic [31:0] exp_icv;
    load_word(16'hFFF8, 32'h04030201);
    load_word(16'hFFFC, 32'h08070605);
    load_word(16'h0000, 32'h11111111);
    for (int k = 0; k < 8; k++) ref_bytes[k] = 8'(k + 1);
    exp_icv = icv_ref(8);
    wb = wr_count;
    do_run(32'hFFF8, 32'd8, e);
    compared++; if (e != 14) begin mismatched++; $display("FAIL wrap_done_edges: got %0d want 14", e); end
    compared++; if (icv !== exp_icv) begin mismatched++; $display("FAIL wrap_icv: got %h want %h", icv, exp_icv); end
    compared++; if (icv_frame_size !== 32'd12) begin mismatched++; $display("FAIL wrap_ifs: got %0d want 12", icv_frame_size); end
    compared++; if (wr_count - wb != 1) begin mismatched++; $display("FAIL wrap_write_count: got %0d want 1", wr_count - wb); end
    compared++; if (wr_addr[wb] !== 16'h0000 || mem[0] !== exp_icv) begin mismatched++; $display("FAIL wrap_write: got %h@%h want %h@0000", mem[0], wr_addr[wb], exp_icv); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n, first, second, pulses, wb;
    logic        busy13, busy14;
    logic [31:0] exp_icv, icv_first;
    load_word(16'h0300, 32'h44332211);
    load_word(16'h0304, 32'h00000055);
    ref_bytes[0] = 8'h11; ref_bytes[1] = 8'h22; ref_bytes[2] = 8'h33;
    ref_bytes[3] = 8'h44; ref_bytes[4] = 8'h55;
    exp_icv = icv_ref(5);
    wb = wr_count;
    first = -1; second = -1; pulses = 0; n = 0;
    busy13 = 1'bx; busy14 = 1'bx; icv_first = 32'h0;
    plain_addr = 32'h300; frame_size = 32'd5; start_icv = 1'b1;
    @(posedge clk); #1;
    while (second < 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) start_icv = 1'b0;
      if (n == 6) start_icv = 1'b1;
      if (n == 13) busy13 = busy;
      if (n == 14) busy14 = busy;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) begin first = n; icv_first = icv; end
        else second = n;
      end
    end
    start_icv = 1'b0;
    compared++; if (first != 12) begin mismatched++; $display("FAIL b2b_first_done: got %0d want 12", first); end
    compared++; if (busy13 !== 1'b0) begin mismatched++; $display("FAIL b2b_busy_idle: got %h want 0", busy13); end
    compared++; if (busy14 !== 1'b1) begin mismatched++; $display("FAIL b2b_busy_restart: got %h want 1", busy14); end
    compared++; if (second != 26) begin mismatched++; $display("FAIL b2b_second_done: got %0d want 26", second); end
    compared++; if (pulses != 2) begin mismatched++; $display("FAIL b2b_done_pulses: got %0d want 2", pulses); end
    compared++; if (icv_first !== exp_icv) begin mismatched++; $display("FAIL b2b_icv: got %h want %h", icv_first, exp_icv); end
    compared++; if (wr_count - wb != 4) begin mismatched++; $display("FAIL b2b_write_count: got %0d want 4", wr_count - wb); end
    compared++; if (wr_addr[wb] !== 16'h0304 || wr_data[wb] !== {exp_icv[23:0], 8'h55}) begin mismatched++; $display("FAIL b2b_write1: got %h@%h want %h@0304", wr_data[wb], wr_addr[wb], {exp_icv[23:0], 8'h55}); end
    compared++; if (wr_addr[wb+1] !== 16'h0308 || wr_data[wb+1] !== {24'd0, exp_icv[31:24]}) begin mismatched++; $display("FAIL b2b_write2: got %h@%h want %h@0308", wr_data[wb+1], wr_addr[wb+1], {24'd0, exp_icv[31:24]}); end
    compared++; if (icv !== exp_icv) begin mismatched++; $display("FAIL b2b_icv_second: got %h want %h", icv, exp_icv); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_icv = 1'b0; plain_addr = '0; frame_size = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_crc_check();
    test_zero_word();
    test_empty_frame();
    test_reset_mid_run();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
